// File: rtl/uart_receiver_pkg.sv
// -----------------------------------------------------------------------------
// UartPkg
//   Definitions shared by the host-link UART receiver and the keyboard-path
//   UART transmitter: receiver FSM state encoding, frame constants and the
//   oversampling clock-divider calculation.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package UartPkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } UartRxState_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_DEFAULT_BAUD = 115200;

    // Clocks per oversampling tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_receiver_rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
//   Show-ahead synchronous FIFO. The head entry is presented on data_o while
//   the FIFO is non-empty (zero otherwise). A push into a full FIFO is only
//   accepted when a pop happens in the same cycle.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push_i       write data_i
//     data_i       write data
//     pop_i        remove head entry (ignored when empty)
//     data_o       head entry
//     full_o       Depth entries stored
//     empty_o      no entries stored
//     count_o      occupancy, 0..Depth
// -----------------------------------------------------------------------------
module rx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem[rd_ptr_q];

    // A full FIFO still takes a push if the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 serial receiver, LSB first, with Oversample-x oversampling. Checks the
//   start bit at mid-bit (glitch rejection) and the stop bit, then buffers
//   received bytes in a show-ahead FIFO with a valid/ready output.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     uartRx        asynchronous serial input, idle high
//     dataOut       head-of-FIFO byte (0 when empty)
//     dataValid     FIFO non-empty
//     dataReady     consumer accepts dataOut on dataValid && dataReady
//     framingError  1-cycle pulse: stop bit sampled low, byte discarded
//     overrun       1-cycle pulse: byte dropped because the FIFO was full
//     fifoCount     FIFO occupancy
// -----------------------------------------------------------------------------
module uart_receiver
    import UartPkg::*;
#(
    parameter int ClkFrequency = 100_000_000,
    parameter int Baud         = UART_DEFAULT_BAUD,
    parameter int Oversample   = 16,
    parameter int FifoDepth    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         uartRx,
    output logic [UART_DATA_BITS-1:0]    dataOut,
    output logic                         dataValid,
    input  logic                         dataReady,
    output logic                         framingError,
    output logic                         overrun,
    output logic [$clog2(FifoDepth):0]   fifoCount
);

    localparam int Div  = calc_div(ClkFrequency, Baud, Oversample);
    localparam int DivW = (Div > 1) ? $clog2(Div) : 1;
    localparam int OsW  = $clog2(Oversample);
    localparam int BitW = $clog2(UART_DATA_BITS);

    logic                      sync1_q;
    logic                      rx_s_q;
    UartRxState_t              state_q, state_d;
    logic [DivW-1:0]           div_q, div_d;
    logic [OsW-1:0]            os_q, os_d;
    logic [BitW-1:0]           bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      tick;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= uartRx;
            rx_s_q  <= sync1_q;
        end
    end

    assign tick = (state_q != IDLE) && (div_q == DivW'(Div - 1));

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        os_d        = os_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        if (state_q != IDLE) begin
            div_d = tick ? '0 : div_q + DivW'(1);
            os_d  = tick ? os_q + OsW'(1) : os_q;
        end

        case (state_q)
            IDLE: begin
                div_d = '0;
                os_d  = '0;
                bit_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Middle of the start bit: a high line here was only a glitch.
                if (tick && os_q == OsW'(Oversample / 2 - 1)) begin
                    os_d    = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && os_q == OsW'(Oversample - 1)) begin
                    os_d    = '0;
                    shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + BitW'(1);
                    if (bit_q == BitW'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && os_q == OsW'(Oversample - 1)) begin
                    os_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must end before hunting for a start bit.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop       = dataValid && dataReady;
    assign overrun_d = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            os_q        <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            os_q        <= os_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign framingError = frame_err_q;
    assign overrun      = overrun_q;
    assign dataValid    = !fifo_empty;

    rx_fifo #(
        .Width (UART_DATA_BITS),
        .Depth (FifoDepth)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (dataOut),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifoCount)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Directed frames into uart_receiver. Expected bytes are queued as frames are
//   sent; a monitor pops and compares on every dataValid && dataReady
//   handshake and counts error pulses. The clock ratio is chosen so one tick is
//   4 clocks (bit period 64 clocks), keeping the run short.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CLK_HZ = 7_372_800;   // 115200 * 16 * 4
    localparam int OS     = 16;
    localparam int DIV    = 4;
    localparam int BIT    = DIV * OS;
    // Cycles from the posedge launching the start bit to the cycle whose end
    // commits the push: 2 sync + half start bit + 9 full bits.
    localparam int PUSH_OFF = 2 + DIV * (OS / 2) + 9 * OS * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uartRx;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       dataReady;
    logic       framingError;
    logic       overrun;
    logic [4:0] fifoCount;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vcnt   = 0;
    logic [7:0] exp_q [$];

    uart_receiver #(
        .ClkFrequency (CLK_HZ),
        .Baud         (115200),
        .Oversample   (OS),
        .FifoDepth    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uartRx       (uartRx),
        .dataOut      (dataOut),
        .dataValid    (dataValid),
        .dataReady    (dataReady),
        .framingError (framingError),
        .overrun      (overrun),
        .fifoCount    (fifoCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dataValid) vcnt++;
            if (framingError) fe_cnt++;
            if (overrun) ov_cnt++;
            if (framingError || overrun) begin
                check("pulse_exclusive", {31'd0, framingError && overrun}, 32'd0);
            end
            if (dataValid && dataReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", dataOut);
                end else begin
                    check("rx_byte", {24'd0, dataOut}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic bit_out(input logic v);
        uartRx = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        uartRx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int v0;
        int fe0;
        int ov0;
        rst_n     = 1'b0;
        uartRx    = 1'b1;
        dataReady = 1'b0;
        idle(5);
        check("rst_dataValid", {31'd0, dataValid}, 32'd0);
        check("rst_dataOut", {24'd0, dataOut}, 32'd0);
        check("rst_framingError", {31'd0, framingError}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_fifoCount", {27'd0, fifoCount}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // 1: two clean frames, consumer always ready.
        dataReady = 1'b1;
        v0 = vcnt;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        idle(BIT);
        check("t1_valid_cycles", vcnt - v0, 32'd2);
        check("t1_left", exp_q.size(), 32'd0);
        check("t1_fe", fe_cnt, 32'd0);
        check("t1_ov", ov_cnt, 32'd0);

        // 2: short low glitch on an idle line.
        v0 = vcnt;
        uartRx = 1'b0;
        idle(3);
        uartRx = 1'b1;
        idle(2 * BIT);
        check("t2_valid_cycles", vcnt - v0, 32'd0);
        check("t2_count", {27'd0, fifoCount}, 32'd0);
        check("t2_fe", fe_cnt, 32'd0);

        // 3: stop bit low, then a good frame.
        send_frame(8'h41, 1'b0);
        idle(BIT);
        check("t3_fe", fe_cnt, 32'd1);
        check("t3_count", {27'd0, fifoCount}, 32'd0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        idle(BIT);
        check("t3_left", exp_q.size(), 32'd0);
        check("t3_fe_after", fe_cnt, 32'd1);

        // 4: fill with consumer stalled, 17th byte overruns.
        dataReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        check("t4_count16", {27'd0, fifoCount}, 32'd16);
        check("t4_ov_before", ov_cnt, 32'd0);
        send_frame(8'h10, 1'b1);
        idle(10);
        check("t4_ov_after", ov_cnt, 32'd1);
        check("t4_count_full", {27'd0, fifoCount}, 32'd16);
        dataReady = 1'b1;
        idle(40);
        check("t4_drained", exp_q.size(), 32'd0);
        check("t4_count0", {27'd0, fifoCount}, 32'd0);

        // 5: full FIFO, one-cycle pop coinciding with the next push.
        dataReady = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h80 + 8'(i));
            send_frame(8'h80 + 8'(i), 1'b1);
        end
        ov0 = ov_cnt;
        exp_q.push_back(8'h90);
        fork
            send_frame(8'h90, 1'b1);
            begin
                repeat (PUSH_OFF) @(posedge clk);
                #1 dataReady = 1'b1;
                @(posedge clk);
                #1 dataReady = 1'b0;
            end
        join
        idle(10);
        check("t5_ov", ov_cnt - ov0, 32'd0);
        check("t5_count", {27'd0, fifoCount}, 32'd16);
        check("t5_queue", exp_q.size(), 32'd16);
        dataReady = 1'b1;
        idle(40);
        check("t5_drained", exp_q.size(), 32'd0);

        // 6: reset mid-frame while a byte is buffered.
        dataReady = 1'b0;
        send_frame(8'h5A, 1'b1);
        idle(10);
        check("t6_buffered", {27'd0, fifoCount}, 32'd1);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        bit_out(1'b0);               // start of 0x7E
        bit_out(1'b0);               // bit 0
        bit_out(1'b1);               // bit 1
        bit_out(1'b1);               // bit 2
        uartRx = 1'b1;               // bit 3, then line stays idle
        idle(BIT / 2);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        check("t6_dataValid", {31'd0, dataValid}, 32'd0);
        check("t6_dataOut", {24'd0, dataOut}, 32'd0);
        check("t6_count", {27'd0, fifoCount}, 32'd0);
        idle(3 * BIT);
        check("t6_fe", fe_cnt - fe0, 32'd0);
        check("t6_ov", ov_cnt - ov0, 32'd0);
        dataReady = 1'b1;
        exp_q.push_back(8'h31);
        send_frame(8'h31, 1'b1);
        idle(BIT);
        check("t6_left", exp_q.size(), 32'd0);
        check("t6_count_end", {27'd0, fifoCount}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
